// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared tag/pick types and the round-robin pick helper for mul_share_arb.
package mul_share_pkg;

    localparam int MAX_R = 16;
    localparam int ID_W  = $clog2(MAX_R);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // Scan ptr, ptr+1, ... mod r; descending loop so the closest hit to ptr wins.
    function automatic pick_t rr_pick(input logic [MAX_R-1:0] valid, input logic [ID_W-1:0] ptr, input int r);
        pick_t p;
        logic [ID_W-1:0] j;
        p = '0;
        for (int k = MAX_R - 1; k >= 0; k--) begin
            j = ID_W'((int'(ptr) + k) % r);
            if (k < r && valid[j]) begin
                p.found = 1'b1;
                p.idx   = j;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin picker; one-hot-or-zero grant starting at ptr.
module rr_grant
    import mul_share_pkg::*;
#(
    parameter  int R  = 4,
    localparam int IW = $clog2(R)
) (
    input  logic          en,
    input  logic [R-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [R-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [MAX_R-1:0] v;
    pick_t            pk;
    logic             unused_idx;

    always_comb begin
        v        = '0;
        v[R-1:0] = valid;
        pk       = rr_pick(v, ID_W'(ptr), R);
        found    = en & pk.found;
        idx      = pk.idx[IW-1:0];
        grant    = found ? (R'(1) << idx) : '0;
    end

    assign unused_idx = ^pk.idx;

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one pipelined AdderTree multiplier among R requesters,
// tracking requester ids alongside the multiplier pipeline.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter  int N   = 3,
    parameter  int R   = 4,
    parameter  int LAT = 2,
    localparam int W   = 2 ** N,
    localparam int IW  = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*W-1:0] req_a,
    input  logic [R*W-1:0] req_b,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_p,
    output logic           rsp_valid,
    output logic [IW-1:0]  rsp_id,
    output logic [2*W-1:0] rsp_p,
    output logic           idle
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic          xfer;
    logic          unused_id;
    // Stage 0 rides with mul_a/mul_b; stages 1..LAT track the AdderTree's own registers.
    tag_t          tag [LAT+1];

    rr_grant #(.R(R)) u_grant (
        .en    (en),
        .valid (req_valid),
        .ptr   (ptr),
        .grant (req_ready),
        .idx   (gidx),
        .found (xfer)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            for (int i = 0; i <= LAT; i++) tag[i] <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else begin
            if (xfer) begin
                ptr   <= (gidx == IW'(R - 1)) ? '0 : gidx + 1'b1;
                mul_a <= req_a[gidx*W +: W];
                mul_b <= req_b[gidx*W +: W];
            end
            tag[0] <= '{valid: xfer, id: ID_W'(gidx)};
            for (int i = 1; i <= LAT; i++) tag[i] <= tag[i-1];
            rsp_valid <= tag[LAT].valid;
            if (tag[LAT].valid) begin
                rsp_id <= tag[LAT].id[IW-1:0];
                rsp_p  <= mul_p;
            end
        end
    end

    always_comb begin
        idle = !rsp_valid;
        for (int i = 0; i <= LAT; i++) if (tag[i].valid) idle = 1'b0;
    end

    assign unused_id = ^tag[LAT].id;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: scoreboard bench with a LAT-stage behavioural multiplier and a spec-level grant model.
module tb_mul_share_arb;

    localparam int N   = 3;
    localparam int R   = 4;
    localparam int LAT = 2;
    localparam int W   = 8;
    localparam int IW  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [R-1:0]   req_valid = '0;
    logic [R-1:0]   req_ready;
    logic [R*W-1:0] req_a = '0;
    logic [R*W-1:0] req_b = '0;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic [2*W-1:0] rsp_p;
    logic           idle;

    typedef struct {
        int id;
        int p;
        int due;
    } exp_t;

    exp_t q[$];
    int   glog[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   mptr = 0;
    logic [2*W-1:0] mpipe [LAT];

    mul_share_arb #(.N(N), .R(R), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .idle      (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // AdderTree stand-in: product appears LAT edges after the operands change.
    always @(posedge clk) begin
        mpipe[0] <= 16'(mul_a) * 16'(mul_b);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_p = mpipe[LAT-1];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    // Issue side: expected grant from the scan rule; each transfer pushes its expected response.
    initial forever begin
        int g, a, b;
        @(negedge clk);
        #1;
        if (rst_n) begin
            g = -1;
            if (en)
                for (int k = R - 1; k >= 0; k--)
                    if (req_valid[(mptr + k) % R]) g = (mptr + k) % R;
            chk("req_ready", int'(req_ready), g < 0 ? 0 : (1 << g));
            if (g >= 0) begin
                a = int'(req_a[g*W +: W]);
                b = int'(req_b[g*W +: W]);
                q.push_back('{id: g, p: a * b, due: cyc + LAT + 2});
                glog.push_back(g);
                mptr = (g + 1) % R;
            end
        end
    end

    // Monitor side: pop and compare whenever a response is presented.
    initial forever begin
        exp_t e;
        logic popped;
        @(negedge clk);
        popped = 1'b0;
        if (rsp_valid) begin
            chk("rsp_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_p", int'(rsp_p), e.p);
                chk("rsp_cycle", cyc, e.due);
                popped = 1'b1;
            end
        end
        while (q.size() > 0 && q[0].due < cyc) begin
            chk("rsp_overdue", q[0].due, cyc);
            void'(q.pop_front());
        end
        chk("idle", int'(idle), int'(q.size() == 0 && !popped));
    end

    initial begin
        tick(2);
        chk("rst_mul_a", int'(mul_a), 0);
        chk("rst_mul_b", int'(mul_b), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_p", int'(rsp_p), 0);
        chk("rst_idle", int'(idle), 1);
        rst_n = 1'b1;
        en = 1'b1;
        tick(1);

        // single op on requester 2
        set_op(2, 12, 10);
        req_valid = 4'b0100;
        glog.delete();
        tick(1);
        req_valid = '0;
        tick(LAT + 3);
        chk("single_grants", glog.size(), 1);

        // all requesters continuously valid; ptr starts at 3 after the single op
        for (int i = 0; i < R; i++) set_op(i, i + 1, 255);
        req_valid = 4'hf;
        glog.delete();
        tick(8);
        req_valid = '0;
        chk("rr_count", glog.size(), 8);
        if (glog.size() == 8)
            for (int i = 0; i < 8; i++) chk("rr_order", glog[i], (3 + i) % R);
        tick(LAT + 3);

        // full-width product
        set_op(3, 255, 255);
        req_valid = 4'b1000;
        tick(1);
        req_valid = '0;
        tick(LAT + 3);

        // en low blocks grants while in-flight ops drain
        for (int i = 0; i < R; i++) set_op(i, 3 * i + 7, 11 + i);
        req_valid = 4'hf;
        tick(3);
        en = 1'b0;
        #1;
        chk("en_off_ready", int'(req_ready), 0);
        tick(LAT + 4);
        chk("en_off_idle", int'(idle), 1);
        en = 1'b1;
        tick(2);
        req_valid = '0;
        tick(LAT + 3);

        // reset with ops in flight discards them
        req_valid = 4'hf;
        tick(LAT);
        rst_n = 1'b0;
        q.delete();
        mptr = 0;
        #1;
        chk("mid_rst_mul_a", int'(mul_a), 0);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_rsp_id", int'(rsp_id), 0);
        chk("mid_rst_rsp_p", int'(rsp_p), 0);
        chk("mid_rst_idle", int'(idle), 1);
        req_valid = '0;
        tick(2);
        rst_n = 1'b1;
        tick(LAT + 3);

        // wrap order: drive ptr to 3, then requesters 1 and 3
        set_op(2, 5, 6);
        req_valid = 4'b0100;
        tick(1);
        set_op(1, 20, 30);
        set_op(3, 40, 50);
        req_valid = 4'b1010;
        glog.delete();
        tick(3);
        req_valid = '0;
        chk("wrap_count", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("wrap_0", glog[0], 3);
            chk("wrap_1", glog[1], 1);
            chk("wrap_2", glog[2], 3);
        end
        tick(LAT + 3);

        // randomized traffic
        repeat (400) begin
            req_valid = R'($urandom);
            en = ($urandom % 8) != 0;
            req_a = $urandom;
            req_b = $urandom;
            tick(1);
        end
        req_valid = '0;
        en = 1'b1;
        tick(LAT + 4);
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
